dadda_cs_accumulator: RTL and testbench

//  Downstream stage of the dadda multiplier. Takes the carry-save pair (z0, z1),

---
 rtl/dadda_cs_accumulator_if.sv | 27 ++
 rtl/dadda_cs_accumulator.sv | 93 +++++++++
 tb/tb_dadda_cs_accumulator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dadda_cs_accumulator_if.sv
// Handshake bundle between the dadda carry-save output, the MAC stage and its result consumer.
// master drives products and takes results; slave is the accumulator itself.
interface dadda_cs_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  z0;
  logic [IN_W-1:0]  z1;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport master (
    output in_valid, z0, z1, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, z0, z1, in_first, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/dadda_cs_accumulator.sv
// Resolves a carry-save product pair and accumulates it; result 2 edges after the input is presented.
// Input stalls only when a finished result is waiting in stage 1 behind an unaccepted output.
module dadda_cs_accumulator #(
  parameter int              IN_W  = 8,
  parameter int              ACC_W = 20,
  parameter logic [IN_W-1:0] CORR  = IN_W'(8'h08),
  parameter bit              SAT   = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  dadda_cs_accumulator_if.slave bus
);

  logic             stall;
  logic             advance;
  logic             p1_valid;
  logic             p1_first;
  logic             p1_last;
  logic [IN_W-1:0]  p1_prod;
  logic [ACC_W-1:0] acc;
  logic             ovf_sticky;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             ov;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             out_valid;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  assign stall         = out_valid & ~bus.out_ready & p1_valid & p1_last;
  assign advance       = p1_valid & ~stall;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = out_acc;
  assign bus.out_ovf   = out_ovf;

  // One extra bit of headroom makes signed overflow a simple top-two-bits compare.
  always_comb begin
    base     = p1_first ? '0 : acc;
    sum      = {base[ACC_W-1], base}
             + {{(ACC_W + 1 - IN_W){p1_prod[IN_W-1]}}, p1_prod};
    ov       = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
    if (SAT && ov) begin
      acc_next = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                            : {1'b0, {(ACC_W - 1){1'b1}}};
    end
    ovf_next = (p1_first ? 1'b0 : ovf_sticky) | ov;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
      p1_prod  <= '0;
    end else if (!stall) begin
      p1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        p1_prod  <= bus.z0 + bus.z1 + CORR;
        p1_first <= bus.in_first;
        p1_last  <= bus.in_last;
      end
    end
  end

  // A result loading in the same cycle the consumer takes the old one keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (advance && p1_last) begin
      out_acc    <= acc_next;
      out_ovf    <= ovf_next;
      out_valid  <= 1'b1;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (advance) begin
        acc        <= acc_next;
        ovf_sticky <= ovf_next;
      end
      if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dadda_cs_accumulator.sv
// Directed and randomized checks of the carry-save MAC stage: reset, latency, MAC, backpressure,
// wrap/saturate overflow, and a scoreboarded random stream.
module tb_dadda_cs_accumulator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  dadda_cs_accumulator_if #(.IN_W(8), .ACC_W(20)) bus ();
  dadda_cs_accumulator_if #(.IN_W(8), .ACC_W(8))  wb ();
  dadda_cs_accumulator_if #(.IN_W(8), .ACC_W(8))  sb ();

  dadda_cs_accumulator #(.IN_W(8), .ACC_W(20), .CORR(8'h08), .SAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  dadda_cs_accumulator #(.IN_W(8), .ACC_W(8), .CORR(8'h08), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(wb.slave));
  dadda_cs_accumulator #(.IN_W(8), .ACC_W(8), .CORR(8'h08), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] a20(input int v);
    logic [19:0] r;
    r = 20'(v);
    return r;
  endfunction

  // Build a carry-save pair whose resolved sum (z0 + z1 + 8'h08) is a*b mod 256.
  function automatic logic [15:0] cs_pair(input int a, input int b);
    logic [7:0] p;
    logic [7:0] c;
    p = 8'(a * b);
    c = 8'(a * 13 + b * 7 + 3);
    return {8'(p - 8'h08 - c), c};
  endfunction

  task automatic send(input int a, input int b, input bit first, input bit last);
    logic [15:0] pr;
    pr = cs_pair(a, b);
    bus.in_valid = 1'b1;
    bus.z0       = pr[15:8];
    bus.z1       = pr[7:0];
    bus.in_first = first;
    bus.in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    check("in_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [19:0] acc, input bit ovf);
    @(negedge clk);
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_acc"}, 32'(bus.out_acc), 32'(acc));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
    @(posedge clk); #1;
  endtask

  task automatic send8(input int a, input int b, input bit first, input bit last);
    logic [15:0] pr;
    pr = cs_pair(a, b);
    wb.in_valid = 1'b1; wb.z0 = pr[15:8]; wb.z1 = pr[7:0]; wb.in_first = first; wb.in_last = last;
    sb.in_valid = 1'b1; sb.z0 = pr[15:8]; sb.z1 = pr[7:0]; sb.in_first = first; sb.in_last = last;
    @(posedge clk); #1;
    wb.in_valid = 1'b0;
    sb.in_valid = 1'b0;
  endtask

  initial begin
    int          pulses;
    logic [19:0] seen_acc;
    logic        seen_ovf;
    int          macc;
    int          sent;
    int          cyc;
    int          ra, rb;
    bit          xfer, rf, rl;
    logic [15:0] pr;
    int          exp_q[$];

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0; bus.z0 = '0; bus.z1 = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    wb.in_valid = 1'b0; wb.z0 = '0; wb.z1 = '0; wb.in_first = 1'b0; wb.in_last = 1'b0;
    wb.out_ready = 1'b1;
    sb.in_valid = 1'b0; sb.z0 = '0; sb.z1 = '0; sb.in_first = 1'b0; sb.in_last = 1'b0;
    sb.out_ready = 1'b1;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_acc", 32'(bus.out_acc), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(posedge clk); #1;

    // T1: pending result plus a partial accumulation, then async reset.
    bus.out_ready = 1'b0;
    send(3, 3, 1'b1, 1'b1);
    send(4, 4, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_pre_vld", 32'(bus.out_valid), 32'd1);
    check("t1_pre_acc", 32'(bus.out_acc), 32'd9);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t1_async_vld", 32'(bus.out_valid), 32'd0);
    check("t1_async_acc", 32'(bus.out_acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(3, 7, 1'b0, 1'b1);
    expect_out("t1_after", a20(21), 1'b0);

    // T2: single products.
    send(0, 0, 1'b1, 1'b1);
    expect_out("t2_0x0", a20(0), 1'b0);
    send(-6, -6, 1'b1, 1'b1);
    expect_out("t2_n6n6", a20(36), 1'b0);
    send(3, 7, 1'b1, 1'b1);
    expect_out("t2_3x7", a20(21), 1'b0);
    send(-8, 7, 1'b1, 1'b1);
    expect_out("t2_n8x7", a20(-56), 1'b0);
    send(-8, -8, 1'b1, 1'b1);
    expect_out("t2_n8n8", a20(64), 1'b0);

    // T3: four-product MAC, one result.
    send(3, 7, 1'b1, 1'b0);
    send(-6, -6, 1'b0, 1'b0);
    send(7, 7, 1'b0, 1'b0);
    send(-8, 7, 1'b0, 1'b1);
    pulses   = 0;
    seen_acc = '0;
    seen_ovf = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        seen_acc = bus.out_acc;
        seen_ovf = bus.out_ovf;
      end
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_acc", 32'(seen_acc), 32'd50);
    check("t3_ovf", 32'(seen_ovf), 32'd0);
    @(posedge clk); #1;

    // T4: two queued results under backpressure.
    bus.out_ready = 1'b0;
    send(3, 7, 1'b1, 1'b1);
    send(2, 5, 1'b1, 1'b1);
    @(negedge clk);
    check("t4_stall_rdy", 32'(bus.in_ready), 32'd0);
    check("t4_hold_vld", 32'(bus.out_valid), 32'd1);
    check("t4_hold_acc", 32'(bus.out_acc), 32'd21);
    repeat (3) @(negedge clk);
    check("t4_still_acc", 32'(bus.out_acc), 32'd21);
    check("t4_still_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_rdy", 32'(bus.in_ready), 32'd1);
    check("t4_first_acc", 32'(bus.out_acc), 32'd21);
    @(negedge clk);
    check("t4_second_vld", 32'(bus.out_valid), 32'd1);
    check("t4_second_acc", 32'(bus.out_acc), 32'd10);
    @(negedge clk);
    check("t4_drained", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // T5: 64 accumulated four times in 8 bits: wrap vs saturate.
    send8(-8, -8, 1'b1, 1'b0);
    send8(-8, -8, 1'b0, 1'b0);
    send8(-8, -8, 1'b0, 1'b0);
    send8(-8, -8, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_wrap_vld", 32'(wb.out_valid), 32'd1);
    check("t5_wrap_acc", 32'(wb.out_acc), 32'd0);
    check("t5_wrap_ovf", 32'(wb.out_ovf), 32'd1);
    check("t5_sat_acc", 32'(sb.out_acc), 32'd127);
    check("t5_sat_ovf", 32'(sb.out_ovf), 32'd1);
    @(posedge clk); #1;
    send8(3, 7, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_wrap_new_acc", 32'(wb.out_acc), 32'd21);
    check("t5_wrap_new_ovf", 32'(wb.out_ovf), 32'd0);
    check("t5_sat_new_ovf", 32'(sb.out_ovf), 32'd0);
    @(posedge clk); #1;

    // T6: random stream against an a*b MAC model.
    macc = 0;
    sent = 0;
    cyc  = 0;
    xfer = 1'b0;
    while ((sent < 400 || exp_q.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (xfer) bus.in_valid = 1'b0;
      xfer = 1'b0;
      if (!bus.in_valid && sent < 400 && $urandom_range(3) != 0) begin
        ra = int'($urandom_range(15)) - 8;
        rb = int'($urandom_range(15)) - 8;
        rf = ($urandom_range(3) == 0);
        rl = ($urandom_range(3) == 0) || (sent == 399);
        pr = cs_pair(ra, rb);
        bus.z0 = pr[15:8]; bus.z1 = pr[7:0]; bus.in_first = rf; bus.in_last = rl;
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious", 32'(bus.out_valid), 32'd0);
        end else begin
          check("t6_acc", 32'(bus.out_acc), 32'(a20(exp_q.pop_front())));
          check("t6_ovf", 32'(bus.out_ovf), 32'd0);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        xfer = 1'b1;
        sent++;
        if (bus.in_first) macc = 0;
        macc += ra * rb;
        if (bus.in_last) begin
          exp_q.push_back(macc);
          macc = 0;
        end
      end
    end
    check("t6_done", 32'(exp_q.size()), 32'd0);
    check("t6_sent", 32'(sent), 32'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
